// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 800x600@60 (40 MHz) timing constants,
// the counter type, and a window helper reused by downstream draw stages.
package vga_pkg;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  // Horizontal timing in pixels
  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing in lines
  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // True when lo <= x < hi
  function automatic logic in_window(cnt_t x, cnt_t lo, cnt_t hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA timing generator: free-running H/V counters with sync, blanking and
// frame-start flags. Flags are derived from the next-state counts so that
// every registered output describes the count values on the same cycle.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        frame_start_out
);

  // Window boundaries, all fit comfortably in 11 bits
  localparam cnt_t H_ACT_END  = cnt_t'(H_ACTIVE);
  localparam cnt_t H_SYNC_LO  = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SYNC_HI  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t H_LAST     = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_ACT_END  = cnt_t'(V_ACTIVE);
  localparam cnt_t V_SYNC_LO  = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SYNC_HI  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t V_LAST     = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  cnt_t hcount_q, hcount_d;
  cnt_t vcount_q, vcount_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic hblnk_q, hblnk_d;
  logic vblnk_q, vblnk_d;
  logic frame_start_q, frame_start_d;
  logic h_wrap, v_last;

  // Next-state counts and the flags that will accompany them
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_last   = (vcount_q == V_LAST);
    hcount_d = h_wrap ? '0 : hcount_q + cnt_t'(1);
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_last ? '0 : vcount_q + cnt_t'(1);
    end
    hblnk_d       = (hcount_d >= H_ACT_END);
    hsync_d       = in_window(hcount_d, H_SYNC_LO, H_SYNC_HI);
    vblnk_d       = (vcount_d >= V_ACT_END);
    vsync_d       = in_window(vcount_d, V_SYNC_LO, V_SYNC_HI);
    // Only a genuine wrap from the last pixel of the last line starts a frame
    frame_start_d = h_wrap && v_last;
  end

  // Counter and flag registers, cleared asynchronously
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;
  assign hsync_out       = hsync_q;
  assign vsync_out       = vsync_q;
  assign hblnk_out       = hblnk_q;
  assign vblnk_out       = vblnk_q;
  assign frame_start_out = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 800x600 instance plus a shrunken instance
// (32x16 total) so whole frames fit in a short run. Expected outputs come from
// the elapsed cycle count since reset release using plain div/mod arithmetic.
module tb_vga_timing;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  logic [10:0] b_h, b_v, s_h, s_v;
  logic b_hs, b_vs, b_hb, b_vb, b_fs;
  logic s_hs, s_vs, s_hb, s_vb, s_fs;

  vga_timing u_big (
    .pclk(pclk), .rst(rst),
    .hcount_out(b_h), .vcount_out(b_v),
    .hsync_out(b_hs), .vsync_out(b_vs),
    .hblnk_out(b_hb), .vblnk_out(b_vb),
    .frame_start_out(b_fs)
  );

  vga_timing #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .pclk(pclk), .rst(rst),
    .hcount_out(s_h), .vcount_out(s_v),
    .hsync_out(s_hs), .vsync_out(s_vs),
    .hblnk_out(s_hb), .vblnk_out(s_vb),
    .frame_start_out(s_fs)
  );

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic hs, vs, hb, vb, fs;
  } tim_t;

  int t = 0;        // rising edges since reset release
  int cyc = 0;      // absolute rising edges
  int checks = 0;
  int errors = 0;
  int fs_count = 0;
  int fs_last = 0;
  int fs_gap = 0;

  // Reference timing derived from elapsed cycles since reset release
  function automatic tim_t model(int tt, int ha, int hfp, int hsw, int hbp,
                                 int va, int vfp, int vsw, int vbp);
    int ht = ha + hfp + hsw + hbp;
    int vt = va + vfp + vsw + vbp;
    int h = tt % ht;
    int v = (tt / ht) % vt;
    tim_t r;
    r.h  = 11'(h);
    r.v  = 11'(v);
    r.hb = (h >= ha);
    r.hs = (h >= ha + hfp) && (h < ha + hfp + hsw);
    r.vb = (v >= va);
    r.vs = (v >= va + vfp) && (v < va + vfp + vsw);
    r.fs = (tt > 0) && ((tt % (ht * vt)) == 0);
    return r;
  endfunction

  task automatic cmp(string tag, logic [10:0] obs, logic [10:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (t=%0d)", tag, obs, expv, t);
    end
  endtask

  task automatic check_all();
    tim_t eb, es;
    eb = model(t, 800, 40, 128, 88, 600, 1, 4, 23);
    es = model(t, 20, 3, 5, 4, 10, 1, 2, 3);
    cmp("big_hcount", b_h, eb.h);
    cmp("big_vcount", b_v, eb.v);
    cmp("big_hsync", {10'd0, b_hs}, {10'd0, eb.hs});
    cmp("big_vsync", {10'd0, b_vs}, {10'd0, eb.vs});
    cmp("big_hblnk", {10'd0, b_hb}, {10'd0, eb.hb});
    cmp("big_vblnk", {10'd0, b_vb}, {10'd0, eb.vb});
    cmp("big_fstart", {10'd0, b_fs}, {10'd0, eb.fs});
    cmp("small_hcount", s_h, es.h);
    cmp("small_vcount", s_v, es.v);
    cmp("small_hsync", {10'd0, s_hs}, {10'd0, es.hs});
    cmp("small_vsync", {10'd0, s_vs}, {10'd0, es.vs});
    cmp("small_hblnk", {10'd0, s_hb}, {10'd0, es.hb});
    cmp("small_vblnk", {10'd0, s_vb}, {10'd0, es.vb});
    cmp("small_fstart", {10'd0, s_fs}, {10'd0, es.fs});
  endtask

  // Advance n cycles, checking every output at each falling edge
  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      cyc++;
      if (!rst) t++;
      @(negedge pclk);
      check_all();
      if (s_fs === 1'b1) begin
        if (fs_count > 0) fs_gap = cyc - fs_last;
        fs_last = cyc;
        fs_count++;
      end
    end
  endtask

  // Assert reset between clock edges, confirm immediate clear, hold, release
  task automatic async_reset(int hold);
    @(posedge pclk);
    cyc++;
    if (!rst) t++;
    #1;
    check_all();
    #($urandom_range(0, 2));
    rst = 1'b1;
    t = 0;
    #1;
    check_all();
    run(hold);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge pclk);
    check_all();
    $display("step reset_hold checked t=%0d", t);
    rst = 1'b0;

    // Two small frames and more than one big line
    n = 1100 + $urandom_range(0, 100);
    run(n);
    cmp("small_fstart_count", 11'(fs_count), 11'd2);
    cmp("small_fstart_period", 11'(fs_gap), 11'd512);
    $display("step free_run cycles=%0d frame_starts=%0d", n, fs_count);

    // Async reset in the middle of big hsync (hcount 900)
    run((900 - (t % 1056) + 1056) % 1056);
    cmp("big_at_900", b_h, 11'd900);
    async_reset($urandom_range(1, 5));
    $display("step async_reset_big_hsync t=%0d", t);

    // Async reset during small vsync (v=11, h=25)
    run((377 - (t % 512) + 512) % 512);
    cmp("small_in_vsync", {10'd0, s_vs}, 11'd1);
    async_reset($urandom_range(1, 5));
    $display("step async_reset_small_vsync t=%0d", t);

    // Randomized run lengths with random resets
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(50, 700);
      run(n);
      async_reset($urandom_range(0, 4));
      $display("step random_run k=%0d cycles=%0d", k, n);
    end
    run(1100);
    $display("step final_run t=%0d", t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
